// File: rtl/qar_i2c_target_pkg.sv
// Shared definitions for the qar_i2c_target peripheral: register map,
// IRQ/STATUS bit positions, FSM encoding and reset own-address.
package qar_i2c_target_pkg;

    localparam logic [5:0] REG_CTRL       = 6'h0;
    localparam logic [5:0] REG_STATUS     = 6'h1;
    localparam logic [5:0] REG_OWN_ADDR   = 6'h2;
    localparam logic [5:0] REG_DATA       = 6'h3;
    localparam logic [5:0] REG_IRQ_EN     = 6'h5;
    localparam logic [5:0] REG_IRQ_STATUS = 6'h6;

    localparam int IRQ_W          = 5;
    localparam int IRQ_RX_AVAIL   = 0;
    localparam int IRQ_ADDR_MATCH = 1;
    localparam int IRQ_STOP       = 2;
    localparam int IRQ_RX_OVF     = 3;
    localparam int IRQ_TX_UNF     = 4;

    localparam int STAT_ADDRESSED = 0;
    localparam int STAT_RW        = 1;
    localparam int STAT_TX_EMPTY  = 2;
    localparam int STAT_TX_FULL   = 3;
    localparam int STAT_RX_EMPTY  = 4;
    localparam int STAT_RX_FULL   = 5;

    localparam logic [6:0] OWN_ADDR_RST = 7'h50;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_BYTE   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_BYTE   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

endpackage

// File: rtl/qar_i2c_sync_edge.sv
// Multi-stage synchroniser for one I2C pin with registered level and
// single-cycle rise/fall pulses derived from the synchronised value.
module qar_i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Idle I2C lines are high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/qar_i2c_target.sv
// Memory-mapped I2C target: address match, RX/TX byte FIFOs, open-drain SDA
// acknowledge/data drive, W1C interrupt status.
module qar_i2c_target
    import qar_i2c_target_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [5:0]  addr_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    output logic        sda_oe,
    output logic [2:0]  dbg_state
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

    logic             r_enable;
    logic [6:0]       r_own_addr;
    logic [IRQ_W-1:0] r_irq_en;
    logic [IRQ_W-1:0] r_irq_status;

    logic [7:0] r_rx_mem [FIFO_DEPTH];
    logic [7:0] r_tx_mem [FIFO_DEPTH];
    logic [AW:0] r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;

    i2c_state_e r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_ack_phase, w_ack_phase_nxt;
    logic       r_ack_ok, w_ack_ok_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_addressed, w_addressed_nxt;

    logic             w_rx_push, w_tx_pop, w_tx_load;
    logic [IRQ_W-1:0] w_irq_set;

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    qar_i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .i_pin(scl_in),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    qar_i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .i_pin(sda_in),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    logic w_start, w_stop;
    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    logic [AW:0] w_rx_cnt, w_tx_cnt;
    logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    assign w_rx_cnt   = r_rx_wr - r_rx_rd;
    assign w_tx_cnt   = r_tx_wr - r_tx_rd;
    assign w_rx_empty = (w_rx_cnt == '0);
    assign w_rx_full  = (w_rx_cnt == DEPTH_P);
    assign w_tx_empty = (w_tx_cnt == '0);
    assign w_tx_full  = (w_tx_cnt == DEPTH_P);

    logic w_wr_ctrl, w_disable, w_rx_pop, w_tx_push;
    logic [IRQ_W-1:0] w_w1c;
    assign w_wr_ctrl = bus_write && (addr_word == REG_CTRL);
    // A write clearing enable takes effect on the very edge that commits it.
    assign w_disable = !r_enable || (w_wr_ctrl && !wdata[0]);
    assign w_rx_pop  = bus_read && (addr_word == REG_DATA) && !w_rx_empty;
    assign w_tx_push = bus_write && (addr_word == REG_DATA) && !w_tx_full;
    assign w_w1c     = (bus_write && (addr_word == REG_IRQ_STATUS)) ? wdata[IRQ_W-1:0] : '0;

    logic [7:0] w_tx_byte, w_rx_byte;
    assign w_tx_byte = w_tx_empty ? 8'hFF : r_tx_mem[r_tx_rd[AW-1:0]];
    assign w_rx_byte = {r_shift[6:0], w_sda};

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_sda_oe_nxt    = r_sda_oe;
        w_ack_phase_nxt = r_ack_phase;
        w_ack_ok_nxt    = r_ack_ok;
        w_rw_nxt        = r_rw;
        w_addressed_nxt = r_addressed;
        w_rx_push       = 1'b0;
        w_tx_pop        = 1'b0;
        w_tx_load       = 1'b0;
        w_irq_set       = '0;
        if (w_disable) begin
            w_state_nxt     = ST_IDLE;
            w_sda_oe_nxt    = 1'b0;
            w_ack_phase_nxt = 1'b0;
            w_addressed_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt         = ST_IDLE;
            w_sda_oe_nxt        = 1'b0;
            w_ack_phase_nxt     = 1'b0;
            w_addressed_nxt     = 1'b0;
            w_irq_set[IRQ_STOP] = r_addressed;
        end else if (w_start) begin
            w_state_nxt     = ST_ADDR;
            w_bit_cnt_nxt   = 3'd7;
            w_sda_oe_nxt    = 1'b0;
            w_ack_phase_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_rx_byte;
                    if (r_bit_cnt != 3'd0) begin
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end else if (r_shift[6:0] == r_own_addr) begin
                        w_rw_nxt                  = w_sda;
                        w_addressed_nxt           = 1'b1;
                        w_irq_set[IRQ_ADDR_MATCH] = 1'b1;
                        w_state_nxt               = ST_ADDR_ACK;
                    end else begin
                        w_state_nxt = ST_WAIT_STOP;
                    end
                end
                // First SCL fall drives the ACK, the second one ends the slot.
                ST_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_ack_phase) begin
                        w_sda_oe_nxt    = 1'b1;
                        w_ack_phase_nxt = 1'b1;
                    end else begin
                        w_ack_phase_nxt = 1'b0;
                        if (r_rw) begin
                            w_tx_load = 1'b1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 3'd7;
                            w_state_nxt   = ST_RX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: if (w_scl_rise) begin
                    w_shift_nxt = w_rx_byte;
                    if (r_bit_cnt != 3'd0) begin
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end else begin
                        w_state_nxt  = ST_RX_ACK;
                        w_ack_ok_nxt = !w_rx_full;
                        if (!w_rx_full) begin
                            w_rx_push               = 1'b1;
                            w_irq_set[IRQ_RX_AVAIL] = 1'b1;
                        end else begin
                            w_irq_set[IRQ_RX_OVF] = 1'b1;
                        end
                    end
                end
                ST_RX_ACK: if (w_scl_fall) begin
                    if (!r_ack_phase) begin
                        w_sda_oe_nxt    = r_ack_ok;
                        w_ack_phase_nxt = 1'b1;
                    end else begin
                        w_sda_oe_nxt    = 1'b0;
                        w_ack_phase_nxt = 1'b0;
                        w_bit_cnt_nxt   = 3'd7;
                        w_state_nxt     = ST_RX_BYTE;
                    end
                end
                ST_TX_BYTE: if (w_scl_fall) begin
                    if (r_bit_cnt == 3'd0) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = ST_TX_ACK;
                    end else begin
                        w_shift_nxt   = {r_shift[6:0], 1'b1};
                        w_sda_oe_nxt  = ~r_shift[6];
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
                ST_TX_ACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state_nxt = ST_WAIT_STOP;
                    end else if (w_scl_fall) begin
                        w_tx_load = 1'b1;
                    end
                end
                ST_WAIT_STOP: w_sda_oe_nxt = 1'b0;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_tx_load) begin
            w_shift_nxt   = w_tx_byte;
            w_sda_oe_nxt  = ~w_tx_byte[7];
            w_bit_cnt_nxt = 3'd7;
            w_state_nxt   = ST_TX_BYTE;
            if (w_tx_empty) w_irq_set[IRQ_TX_UNF] = 1'b1;
            else            w_tx_pop = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_sda_oe    <= 1'b0;
            r_ack_phase <= 1'b0;
            r_ack_ok    <= 1'b0;
            r_rw        <= 1'b0;
            r_addressed <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_ack_phase <= w_ack_phase_nxt;
            r_ack_ok    <= w_ack_ok_nxt;
            r_rw        <= w_rw_nxt;
            r_addressed <= w_addressed_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_rx_mem[i] <= 8'd0;
                r_tx_mem[i] <= 8'd0;
            end
            r_rx_wr <= '0;
            r_rx_rd <= '0;
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wr[AW-1:0]] <= w_rx_byte;
                r_rx_wr                   <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
            if (w_tx_push) begin
                r_tx_mem[r_tx_wr[AW-1:0]] <= wdata[7:0];
                r_tx_wr                   <= r_tx_wr + 1'b1;
            end
            if (w_tx_pop) r_tx_rd <= r_tx_rd + 1'b1;
        end
    end

    // Hardware sets are ORed in after the W1C mask, so a set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable     <= 1'b1;
            r_own_addr   <= OWN_ADDR_RST;
            r_irq_en     <= '0;
            r_irq_status <= '0;
        end else begin
            if (w_wr_ctrl) r_enable <= wdata[0];
            if (bus_write && (addr_word == REG_OWN_ADDR)) r_own_addr <= wdata[6:0];
            if (bus_write && (addr_word == REG_IRQ_EN))   r_irq_en   <= wdata[IRQ_W-1:0];
            r_irq_status <= (r_irq_status & ~w_w1c) | w_irq_set;
        end
    end

    always_comb begin
        rdata = '0;
        if (bus_read) begin
            case (addr_word)
                REG_CTRL:       rdata[0]       = r_enable;
                REG_STATUS:     rdata[5:0]     = {w_rx_full, w_rx_empty, w_tx_full,
                                                  w_tx_empty, r_rw, r_addressed};
                REG_OWN_ADDR:   rdata[6:0]     = r_own_addr;
                REG_DATA:       rdata[7:0]     = r_rx_mem[r_rx_rd[AW-1:0]];
                REG_IRQ_EN:     rdata[IRQ_W-1:0] = r_irq_en;
                REG_IRQ_STATUS: rdata[IRQ_W-1:0] = r_irq_status;
                default:        rdata          = '0;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, wdata[31:8]};

    assign irq       = |(r_irq_en & r_irq_status);
    assign sda_out   = 1'b0;
    assign sda_oe    = r_sda_oe;
    assign dbg_state = r_state;

endmodule

// File: doc/qar_i2c_target.md
Name: qar_i2c_target

Overview:
- Memory-mapped I2C target (slave) peripheral. It is the responder counterpart of the existing qar_i2c controller and uses the same 6-bit word-addressed register bus and irq style.
- Watches external SCL/SDA, matches a programmable 7-bit address, and ACKs. Received bytes go to an RX FIFO; bytes for controller reads come from a CPU-filled TX FIFO.
- Open-drain SDA only. No clock stretching, no SCL drive.

Parameters:
- FIFO_DEPTH, 4, entries per RX/TX FIFO. Power of two, ≥2.
- SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in. Must be ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bus_write  in  1  register write strobe, one cycle
- bus_read  in  1  register read strobe, one cycle
- addr_word  in  6  register word index
- wdata  in  32  write data
- rdata  out  32  combinational read data; 0 when bus_read=0
- irq  out  1  |(irq_en & irq_status)
- scl_in  in  1  SCL pin level
- sda_in  in  1  SDA pin level
- sda_out  out  1  constant 0 (open-drain low)
- sda_oe  out  1  1 = pull SDA low

Behaviour:
- Registers:
  - 0x0 CTRL: bit0 enable. Reset value 1.
  - 0x1 STATUS, read-only: bit0 addressed, bit1 rw (1 = controller read), bit2 tx_empty, bit3 tx_full, bit4 rx_empty, bit5 rx_full.
  - 0x2 OWN_ADDR[6:0]. Reset value 0x50.
  - 0x3 DATA: a write pushes the TX FIFO; a read returns the RX head and pops it.
  - 0x5 IRQ_EN. Reset value 0.
  - 0x6 IRQ_STATUS, W1C: bit0 rx_avail, bit1 addr_match, bit2 stop, bit3 rx_overflow, bit4 tx_underflow.
- Reset values: rdata=0, irq=0, sda_out=0, sda_oe=0, FSM=IDLE, FIFO pointers 0.
- FIFOs use head/tail pointers with one extra wrap bit. full = difference equals FIFO_DEPTH; empty = pointers equal.
  - A push when full is dropped silently.
  - A pop when empty changes nothing; rdata returns the stale entry.
- A hardware set and a W1C of the same IRQ_STATUS bit in the same cycle: the set wins.
- Pin handling: synchronise both pins, then detect edges on the synced values. Internal response is SYNC_STAGES+1 clk after a pin edge. The controller's SCL half-period must be ≥ 2*(SYNC_STAGES+2) clk.
- START: synced SDA falls while SCL is high. Valid from any state, including a repeated start; go to ADDR with bit count 7.
- STOP: synced SDA rises while SCL is high. From any state: go to IDLE, sda_oe=0, addressed=0. If addressed was 1, set irq bit2.
- Data is sampled on SCL rising edges. sda_oe changes only on SCL falling edges (plus the STOP/disable cases).
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
    - If bits[7:1] equal OWN_ADDR: latch rw=bit0, set addressed=1, set irq bit1, go to ADDR_ACK.
    - Otherwise go to WAIT_STOP with sda_oe never asserted.
  - ADDR_ACK: sda_oe=1 from the falling edge after bit 8 to the next falling edge. Then:
    - rw=0: go to RX_BYTE.
    - rw=1: go to TX_BYTE, pop TX and drive its bit7.
  - RX_BYTE: shift 8 bits, then go to RX_ACK.
    - RX not full: push the byte, set irq bit0, ACK.
    - RX full: drop the byte, set irq bit3, NACK (sda_oe=0).
    - Either way return to RX_BYTE.
  - TX_BYTE: on each SCL fall, sda_oe = ~current bit. After 8 bits release SDA and go to TX_ACK.
    - TX empty at load time: send 0xFF and set irq bit4.
  - TX_ACK: sample SDA on the rising edge.
    - 0 (ACK): load the next byte at the falling edge and return to TX_BYTE.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0; ignore data until START or STOP.
- enable=0: IDLE and sda_oe=0 in the next cycle; FIFOs are kept.
- Reset mid-transfer releases SDA immediately.
- General call and 10-bit addressing are not supported.

Decomposition:
- Shared package holds: register word offsets, IRQ/STATUS bit positions, FSM state encodings, reset OWN_ADDR.
- Sub-module qar_i2c_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiate it twice, once for SCL and once for SDA.
- FIFOs stay inline.

Test Plan:
- Write 0x42: OWN_ADDR=0x42; controller sends START, 0x84, 0xA5, STOP.
  - Required: ACK on both bytes; irq_status=0x07; DATA read=0xA5; then rx_empty=1.
- Read two bytes: TX preloaded 0x3C, 0x5A; controller sends START, 0x85, reads 2 bytes (ACK then NACK), STOP.
  - Required: SDA shows 0x3C then 0x5A; tx_empty=1; no bit4.
- Mismatch: START, 0x86, data.
  - Required: sda_oe stays 0 throughout; irq_status=0 apart from nothing.
- RX overflow: 5 data bytes after address 0x84 with DEPTH=4.
  - Required: bytes 1-4 ACKed, byte 5 NACKed; bit3 set; pops return bytes 1-4 in order.
- TX underflow plus repeated start: read with TX empty.
  - Required: 0xFF on SDA and bit4 set. Then Sr + 0x84 + 0x11 is accepted; rw=0.
- Disable mid-byte: clear CTRL.enable during ADDR_ACK.
  - Required: sda_oe=0 within 1 clk; next START is ignored until re-enabled.
